// File: rtl/ysyx_22041412_csr_seq_if.sv
// Port bundle between the CSR sequencer (master) and the single-port machine CSR file (slave).
interface ysyx_22041412_csr_seq_if #(
  parameter int unsigned AW = 2
);
  logic          csr_en;
  logic [AW-1:0] csr_addr;
  logic [2:0]    csr_func3;
  logic [63:0]   csr_wdata;
  logic [63:0]   csr_rdata;
  logic          csr_ready;

  modport master (
    output csr_en, csr_addr, csr_func3, csr_wdata,
    input  csr_rdata, csr_ready
  );

  modport slave (
    input  csr_en, csr_addr, csr_func3, csr_wdata,
    output csr_rdata, csr_ready
  );
endinterface

// File: rtl/ysyx_22041412_csr_seq.sv
// Expands Zicsr / ECALL / MRET requests into ordered accesses on the single CSR file port,
// returning old CSR data or a PC redirect, with a per-access ready timeout.
module ysyx_22041412_csr_seq #(
  parameter int unsigned AW        = 2,
  parameter int unsigned IDX_MTVEC = 0,
  parameter int unsigned IDX_MEPC  = 1,
  parameter int unsigned IDX_MCAUS = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_ecall,
  input  logic          req_mret,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_func3,
  input  logic [63:0]   req_wdata,
  input  logic [63:0]   req_pc,
  output logic          done,
  output logic [63:0]   rdata,
  output logic          redirect,
  output logic [63:0]   redirect_pc,
  output logic          err,
  ysyx_22041412_csr_seq_if.master csr
);

  typedef enum logic [2:0] {
    S_IDLE, S_CSR, S_E_EPC, S_E_CAU, S_E_VEC, S_R_EPC, S_DONE
  } state_t;

  typedef enum logic [1:0] { K_CSR, K_ECALL, K_MRET } kind_t;

  state_t        state_q, state_d, acc_next;
  kind_t         kind_q, kind_d;
  logic [63:0]   pc_q, pc_d, wdata_q, wdata_d, rdata_q, rdata_d, rpc_q, rpc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    func3_q, func3_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d, acc;

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    func3_d       = func3_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rpc_d         = rpc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    acc           = 1'b0;
    acc_next      = S_DONE;
    req_ready     = 1'b0;
    done          = 1'b0;
    redirect      = 1'b0;
    err           = 1'b0;
    csr.csr_addr  = '0;
    csr.csr_func3 = '0;
    csr.csr_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pc_d    = req_pc;
          addr_d  = req_addr;
          func3_d = req_func3;
          wdata_d = req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (req_ecall) begin
            kind_d  = K_ECALL;
            state_d = S_E_EPC;
          end else if (req_mret) begin
            kind_d  = K_MRET;
            state_d = S_R_EPC;
          end else begin
            kind_d  = K_CSR;
            state_d = S_CSR;
          end
        end
      end
      S_CSR: begin
        acc           = 1'b1;
        csr.csr_addr  = addr_q;
        csr.csr_func3 = func3_q;
        csr.csr_wdata = wdata_q;
      end
      S_E_EPC: begin
        acc           = 1'b1;
        csr.csr_addr  = AW'(IDX_MEPC);
        csr.csr_func3 = 3'b001;
        csr.csr_wdata = pc_q;
        acc_next      = S_E_CAU;
      end
      S_E_CAU: begin
        acc           = 1'b1;
        csr.csr_addr  = AW'(IDX_MCAUS);
        csr.csr_func3 = 3'b001;
        csr.csr_wdata = 64'd11;
        acc_next      = S_E_VEC;
      end
      S_E_VEC: begin
        acc           = 1'b1;
        csr.csr_addr  = AW'(IDX_MTVEC);
        csr.csr_func3 = 3'b010;
      end
      S_R_EPC: begin
        acc           = 1'b1;
        csr.csr_addr  = AW'(IDX_MEPC);
        csr.csr_func3 = 3'b010;
      end
      S_DONE: begin
        done     = 1'b1;
        err      = err_q;
        redirect = (kind_q != K_CSR) && !err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared advance/timeout path for every access state; a timeout skips any remaining accesses.
    if (acc) begin
      if (csr.csr_ready) begin
        state_d = acc_next;
        cnt_d   = '0;
        if (state_q == S_CSR) rdata_d = csr.csr_rdata;
        else if (state_q == S_E_VEC || state_q == S_R_EPC) rpc_d = csr.csr_rdata;
      end else if (cnt_q == 4'(TIMEOUT - 1)) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    csr.csr_en = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_CSR;
      pc_q    <= '0;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rpc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rdata       = rdata_q;
  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_ysyx_22041412_csr_seq.sv
// Bench for ysyx_22041412_csr_seq: CSR file model with optional stalls, directed cases, then random requests.
module tb_ysyx_22041412_csr_seq;
  localparam int unsigned AW      = 2;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ecall = 1'b0, req_mret = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_func3 = '0;
  logic [63:0]   req_wdata = '0, req_pc = '0;
  logic          req_ready, done, redirect, err;
  logic [63:0]   rdata, redirect_pc;

  always #5 clk = ~clk;

  ysyx_22041412_csr_seq_if #(.AW(AW)) csr_bus ();

  ysyx_22041412_csr_seq #(
    .AW(AW), .IDX_MTVEC(0), .IDX_MEPC(1), .IDX_MCAUS(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ecall(req_ecall), .req_mret(req_mret),
    .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata), .req_pc(req_pc),
    .done(done), .rdata(rdata), .redirect(redirect), .redirect_pc(redirect_pc), .err(err),
    .csr(csr_bus)
  );

  typedef struct packed { logic [1:0] a; logic [2:0] f; logic [63:0] w; } acc_t;

  function automatic logic [63:0] csr_op(input logic [2:0] f, input logic [63:0] o, input logic [63:0] w);
    case (f[1:0])
      2'b01:   return w;
      2'b10:   return o | w;
      2'b11:   return o & ~w;
      default: return o;
    endcase
  endfunction

  // CSR file model: one-cycle ready pulse after en is seen, plus 0..delay_max extra stall cycles
  acc_t        acc_log[$];
  logic [63:0] mem [4];
  bit          init_mem = 1'b1, stuck = 1'b0, busy;
  int unsigned delay_max = 0, dly, rnd_d;

  always @(negedge clk) rnd_d <= $urandom_range(delay_max, 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_bus.csr_ready <= 1'b0;
      csr_bus.csr_rdata <= '0;
      busy <= 1'b0;
      dly  <= 0;
      if (init_mem) begin
        mem[0] <= 64'h8000_0400;
        mem[1] <= 64'h10;
        mem[2] <= '0;
        mem[3] <= '0;
      end
    end else begin
      csr_bus.csr_ready <= 1'b0;
      if (busy) begin
        if (dly == 0) begin
          busy <= 1'b0;
          csr_bus.csr_ready <= 1'b1;
          csr_bus.csr_rdata <= mem[csr_bus.csr_addr];
          mem[csr_bus.csr_addr] <= csr_op(csr_bus.csr_func3, mem[csr_bus.csr_addr], csr_bus.csr_wdata);
        end else dly <= dly - 1;
      end else if (csr_bus.csr_en && !csr_bus.csr_ready && !stuck) begin
        acc_log.push_back(acc_t'{a: csr_bus.csr_addr, f: csr_bus.csr_func3, w: csr_bus.csr_wdata});
        if (rnd_d == 0) begin
          csr_bus.csr_ready <= 1'b1;
          csr_bus.csr_rdata <= mem[csr_bus.csr_addr];
          mem[csr_bus.csr_addr] <= csr_op(csr_bus.csr_func3, mem[csr_bus.csr_addr], csr_bus.csr_wdata);
        end else begin
          busy <= 1'b1;
          dly  <= rnd_d - 1;
        end
      end
    end
  end

  // Reference state: architectural CSR contents and the expected held outputs
  logic [63:0] ref_csr [4];
  logic [63:0] exp_rdata = '0, exp_rpc = '0;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_redirect"}, 64'(redirect), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_csr_en"}, 64'(csr_bus.csr_en), 64'd0);
    chk({tag, "_csr_addr"}, 64'(csr_bus.csr_addr), 64'd0);
    chk({tag, "_csr_func3"}, 64'(csr_bus.csr_func3), 64'd0);
    chk({tag, "_csr_wdata"}, csr_bus.csr_wdata, 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
  endtask

  // Issue one request from a negedge, wait for done, compare results and the issued access list.
  task automatic run_req(input bit ec, input bit mr, input logic [1:0] a, input logic [2:0] f,
                         input logic [63:0] w, input logic [63:0] pc,
                         input bit lat_chk, input bit hold, input bit exp_err);
    acc_t ex[$];
    int   base, n, nlog;
    bit   exp_redir;
    exp_redir = (ec || mr) && !exp_err;
    if (exp_err) begin
      // nothing issued, nothing captured
    end else if (ec) begin
      ex.push_back(acc_t'{a: 2'd1, f: 3'b001, w: pc});
      ex.push_back(acc_t'{a: 2'd2, f: 3'b001, w: 64'd11});
      ex.push_back(acc_t'{a: 2'd0, f: 3'b010, w: 64'd0});
      ref_csr[1] = pc;
      ref_csr[2] = 64'd11;
      exp_rpc    = ref_csr[0];
    end else if (mr) begin
      ex.push_back(acc_t'{a: 2'd1, f: 3'b010, w: 64'd0});
      exp_rpc = ref_csr[1];
    end else begin
      ex.push_back(acc_t'{a: a, f: f, w: w});
      exp_rdata  = ref_csr[a];
      ref_csr[a] = csr_op(f, ref_csr[a], w);
    end

    chk("ready_before", 64'(req_ready), 64'd1);
    base = acc_log.size();
    req_ecall = ec; req_mret = mr; req_addr = a; req_func3 = f; req_wdata = w; req_pc = pc;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_ecall = 1'b0; req_mret = 1'b0; req_addr = 2'($urandom);
    req_func3 = 3'b001; req_wdata = {$urandom, $urandom}; req_pc = {$urandom, $urandom};
    if (hold) chk("ready_busy", 64'(req_ready), 64'd0);
    else req_valid = 1'b0;

    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("done", 64'(done), 64'd1);
    if (lat_chk) chk("latency", 64'(n + 1), exp_err ? 64'(TIMEOUT + 1) : 64'(2 * ex.size() + 1));
    chk("redirect", 64'(redirect), 64'(exp_redir));
    chk("err", 64'(err), 64'(exp_err));
    chk("rdata", rdata, exp_rdata);
    chk("redirect_pc", redirect_pc, exp_rpc);
    chk("csr_en_done", 64'(csr_bus.csr_en), 64'd0);

    nlog = acc_log.size() - base;
    chk("acc_count", 64'(nlog), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < nlog; i++) begin
      chk("acc_addr", 64'(acc_log[base + i].a), 64'(ex[i].a));
      chk("acc_func3", 64'(acc_log[base + i].f), 64'(ex[i].f));
      chk("acc_wdata", acc_log[base + i].w, ex[i].w);
    end

    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("ready_after", 64'(req_ready), 64'd1);
    @(negedge clk);
  endtask

  logic [2:0] f3_set [6];
  int base_r;

  initial begin
    f3_set = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    ref_csr[0] = 64'h8000_0400;
    ref_csr[1] = 64'h10;
    ref_csr[2] = '0;
    ref_csr[3] = '0;

    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset_low");
    @(negedge clk);
    rst_n = 1'b1;
    init_mem = 1'b0;
    #1 check_idle_outputs("reset_rel");
    @(negedge clk);

    run_req(1'b0, 1'b0, 2'd1, 3'b001, 64'h80, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("zicsr_rdata", rdata, 64'h10);
    run_req(1'b1, 1'b0, 2'd0, 3'b000, 64'h0, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
    chk("ecall_pc", redirect_pc, 64'h8000_0400);
    run_req(1'b0, 1'b1, 2'd0, 3'b000, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("mret_pc", redirect_pc, 64'h8000_0100);
    run_req(1'b1, 1'b1, 2'd3, 3'b010, 64'h5, 64'h8000_0200, 1'b1, 1'b1, 1'b0);

    stuck = 1'b1;
    run_req(1'b0, 1'b0, 2'd3, 3'b001, 64'hdead, 64'h0, 1'b1, 1'b0, 1'b1);
    stuck = 1'b0;

    // Reset while the mcause write is on the port
    base_r = acc_log.size();
    req_ecall = 1'b1; req_pc = 64'h8000_0300; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_ecall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ecau_addr", 64'(csr_bus.csr_addr), 64'd2);
    chk("ecau_en", 64'(csr_bus.csr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_csr_en", 64'(csr_bus.csr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    ref_csr[1] = 64'h8000_0300;
    exp_rdata = '0;
    exp_rpc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_idle_outputs("rst_mid");
    chk("rst_acc_count", 64'(acc_log.size() - base_r), 64'd1);
    @(negedge clk);
    run_req(1'b1, 1'b0, 2'd0, 3'b000, 64'h0, 64'h8000_0500, 1'b1, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      delay_max = $urandom_range(3, 0);
      r = $urandom_range(9, 0);
      @(negedge clk);
      run_req(r < 2, (r < 4) ? 1'($urandom) : 1'b0, 2'($urandom), f3_set[$urandom_range(5, 0)],
              {$urandom, $urandom}, {$urandom, $urandom}, delay_max == 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
